// File: rtl/sdr_link_pkg.sv
// Shared definitions for the SDR FTDI link: FSM encodings, burst header layout
// and IQ word packing used by the upstream scheduler.
package sdr_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_IQ_DATA  = 2'd1,
    ST_CPU_DATA = 2'd2
  } a2f_state_e;

  typedef enum logic {
    SRC_IQ  = 1'b0,
    SRC_CPU = 1'b1
  } a2f_src_e;

  localparam int   HDR_TYPE_BIT = 31;
  localparam logic HDR_TOFIFO   = 1'b0;
  localparam logic HDR_TOCPU    = 1'b1;
  localparam int   IQ_CNT_LSB   = 0;
  localparam int   IQ_CNT_W     = 16;
  localparam int   CPU_CNT_LSB  = 20;
  localparam int   CPU_CNT_W    = 8;
  localparam int   IQ_HALF_W    = 12;

  // Spreads a packed {Q,I} pair into an FTDI word: I at [11:0], Q at qstart.
  function automatic logic [31:0] iq_pack(input logic [23:0] pair, input int qstart);
    logic [31:0] w;
    w = '0;
    for (int b = 0; b < IQ_HALF_W; b++) begin
      w[b]          = pair[b];
      w[qstart + b] = pair[IQ_HALF_W + b];
    end
    return w;
  endfunction

endpackage

// File: rtl/sel_a2f_rr2.sv
// Two-way picker between IQ and CPU requests. Round-robin on ties by default;
// with SEL_A2F_CPU_PRIO_EN defined the CPU always wins ties.
module sel_a2f_rr2
  import sdr_link_pkg::*;
(
  input  logic clk_i,
  input  logic reset,
  input  logic iq_req_i,
  input  logic cpu_req_i,
  input  logic upd_i,
  input  logic upd_cpu_i,
  output logic grant_iq_o,
  output logic grant_cpu_o
);

`ifdef SEL_A2F_CPU_PRIO_EN
  logic unused_rr_inputs;
  assign unused_rr_inputs = ^{clk_i, reset, upd_i, upd_cpu_i};

  always_comb begin
    grant_cpu_o = cpu_req_i;
    grant_iq_o  = iq_req_i & ~cpu_req_i;
  end
`else
  a2f_src_e last_grant_q, last_grant_d;

  always_comb begin
    last_grant_d = last_grant_q;
    if (upd_i) last_grant_d = upd_cpu_i ? SRC_CPU : SRC_IQ;
  end

  // The source that did not win last time takes a tie.
  always_comb begin
    grant_iq_o  = iq_req_i & (~cpu_req_i | (last_grant_q == SRC_CPU));
    grant_cpu_o = cpu_req_i & ~grant_iq_o;
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) last_grant_q <= SRC_CPU;
    else       last_grant_q <= last_grant_d;
  end
`endif

endmodule

// File: rtl/sel_a2f_arb.sv
// Upstream FTDI packet scheduler: frames IQ and ECPU bursts with a header word.
// Optional macro SEL_A2F_CPU_PRIO_EN gives the CPU strict priority on ties.
module sel_a2f_arb
  import sdr_link_pkg::*;
#(
  parameter int FT_DATA_WIDTH    = 32,
  parameter int IQ_PAIR_WIDTH    = 24,
  parameter int QSTART_BIT_INDEX = 16,
  parameter int IQ_BURST_LEN     = 256
) (
  input  logic                     clk_i,
  input  logic                     reset,
  input  logic                     en_i,
  input  logic [IQ_PAIR_WIDTH-1:0] iq_data_i,
  input  logic                     iq_empty_i,
  input  logic                     iq_enough_i,
  output logic                     iq_rd_o,
  input  logic                     cpu_req_i,
  input  logic [7:0]               cpu_len_i,
  input  logic [FT_DATA_WIDTH-1:0] cpu_data_i,
  input  logic                     cpu_valid_i,
  output logic                     cpu_rd_o,
  output logic                     cpu_ack_o,
  output logic [FT_DATA_WIDTH-1:0] ft_data_o,
  output logic                     ft_we_o,
  input  logic                     ft_full_i,
  output logic                     pkt_done_o
);

  localparam logic [15:0] IQ_LEN = 16'(IQ_BURST_LEN);

  a2f_state_e               state_q, state_d;
  logic [15:0]              cnt_q, cnt_d, len_q, len_d, cnt_inc;
  logic [FT_DATA_WIDTH-1:0] ft_data_q, ft_data_d;
  logic                     ft_we_q, ft_we_d;
  logic                     cpu_ack_q, cpu_ack_d;
  logic                     pkt_done_q, pkt_done_d;

  logic                     out_free, iq_req, cpu_req;
  logic                     grant_iq, grant_cpu, lg_upd, lg_upd_cpu;
  logic [FT_DATA_WIDTH-1:0] hdr_iq, hdr_cpu, iq_word;

  assign out_free = ~ft_we_q | ~ft_full_i;
  assign cnt_inc  = cnt_q + 16'd1;
  assign iq_req   = en_i & iq_enough_i;
  // The request still seen during the ack cycle is the one just granted.
  assign cpu_req  = en_i & cpu_req_i & ~cpu_ack_q;

  always_comb begin
    hdr_iq                              = '0;
    hdr_iq[HDR_TYPE_BIT]                = HDR_TOFIFO;
    hdr_iq[IQ_CNT_LSB +: IQ_CNT_W]      = IQ_LEN;
    hdr_cpu                             = '0;
    hdr_cpu[HDR_TYPE_BIT]               = HDR_TOCPU;
    hdr_cpu[CPU_CNT_LSB +: CPU_CNT_W]   = cpu_len_i;
    iq_word = FT_DATA_WIDTH'(iq_pack(24'(iq_data_i), QSTART_BIT_INDEX));
  end

  sel_a2f_rr2 u_rr2 (
    .clk_i       (clk_i),
    .reset       (reset),
    .iq_req_i    (iq_req),
    .cpu_req_i   (cpu_req),
    .upd_i       (lg_upd),
    .upd_cpu_i   (lg_upd_cpu),
    .grant_iq_o  (grant_iq),
    .grant_cpu_o (grant_cpu)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    ft_data_d  = ft_data_q;
    ft_we_d    = ft_we_q;
    cpu_ack_d  = 1'b0;
    pkt_done_d = 1'b0;
    iq_rd_o    = 1'b0;
    cpu_rd_o   = 1'b0;
    lg_upd     = 1'b0;
    lg_upd_cpu = 1'b0;

    if (out_free) begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (grant_iq) begin
            ft_data_d = hdr_iq;
            ft_we_d   = 1'b1;
            len_d     = IQ_LEN;
            state_d   = ST_IQ_DATA;
          end else if (grant_cpu) begin
            ft_data_d = hdr_cpu;
            ft_we_d   = 1'b1;
            cpu_ack_d = 1'b1;
            len_d     = {8'h00, cpu_len_i};
            if (cpu_len_i == 8'h00) begin
              pkt_done_d = 1'b1;
              lg_upd     = 1'b1;
              lg_upd_cpu = 1'b1;
            end else begin
              state_d = ST_CPU_DATA;
            end
          end else begin
            ft_we_d = 1'b0;
          end
        end
        ST_IQ_DATA, ST_CPU_DATA: begin
          if ((state_q == ST_IQ_DATA) ? ~iq_empty_i : cpu_valid_i) begin
            ft_data_d = (state_q == ST_IQ_DATA) ? iq_word : cpu_data_i;
            ft_we_d   = 1'b1;
            iq_rd_o   = (state_q == ST_IQ_DATA);
            cpu_rd_o  = (state_q == ST_CPU_DATA);
            cnt_d     = cnt_inc;
            if (cnt_inc == len_q) begin
              pkt_done_d = 1'b1;
              cnt_d      = '0;
              lg_upd     = 1'b1;
              lg_upd_cpu = (state_q == ST_CPU_DATA);
              state_d    = ST_IDLE;
            end
          end else begin
            ft_we_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          ft_we_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      ft_data_q  <= '0;
      ft_we_q    <= 1'b0;
      cpu_ack_q  <= 1'b0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      ft_data_q  <= ft_data_d;
      ft_we_q    <= ft_we_d;
      cpu_ack_q  <= cpu_ack_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  assign ft_data_o  = ft_data_q;
  assign ft_we_o    = ft_we_q;
  assign cpu_ack_o  = cpu_ack_q;
  assign pkt_done_o = pkt_done_q;

endmodule

// File: tb/tb_sel_a2f_arb.sv
// Directed bench for sel_a2f_arb with IQ_BURST_LEN=4 and FWFT FIFO models.
module tb_sel_a2f_arb;

  localparam int W  = 32;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en_i;
  logic [23:0]   iq_data_i;
  logic          iq_empty_i, iq_enough_i, iq_rd_o;
  logic          cpu_req_i;
  logic [7:0]    cpu_len_i;
  logic [W-1:0]  cpu_data_i;
  logic          cpu_valid_i, cpu_rd_o, cpu_ack_o;
  logic [W-1:0]  ft_data_o;
  logic          ft_we_o, ft_full_i, pkt_done_o;

  always #5 clk = ~clk;

  sel_a2f_arb #(.IQ_BURST_LEN(BL)) dut (
    .clk_i       (clk),
    .reset       (rst),
    .en_i        (en_i),
    .iq_data_i   (iq_data_i),
    .iq_empty_i  (iq_empty_i),
    .iq_enough_i (iq_enough_i),
    .iq_rd_o     (iq_rd_o),
    .cpu_req_i   (cpu_req_i),
    .cpu_len_i   (cpu_len_i),
    .cpu_data_i  (cpu_data_i),
    .cpu_valid_i (cpu_valid_i),
    .cpu_rd_o    (cpu_rd_o),
    .cpu_ack_o   (cpu_ack_o),
    .ft_data_o   (ft_data_o),
    .ft_we_o     (ft_we_o),
    .ft_full_i   (ft_full_i),
    .pkt_done_o  (pkt_done_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Stimulus tables: {Q,I} pairs and their hand-packed FTDI words.
  logic [23:0] t_pair [4] = '{24'h123456, 24'hABCDEF, 24'h000FFF, 24'hFFF000};
  logic [31:0] t_word [4] = '{32'h01230456, 32'h0ABC0DEF, 32'h00000FFF, 32'h0FFF0000};
  logic [31:0] c_word [3] = '{32'h10000011, 32'h10000022, 32'h10000033};

  logic [23:0]  iq_fifo[$];
  logic [W-1:0] cpu_fifo[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];

  int cyc = 0, done_cnt, ack_cnt, cpu_rd_cnt, pop_viol, done_cyc, ack_cyc;
  int cpu_gap = 0, cpu_acks_left = 0;
  logic cpu_gap_arm = 1'b0;
  logic [31:0] done_word;
  logic p_iq, p_cpu, p_ack;

  function automatic void fifo_refresh();
    iq_data_i   = (iq_fifo.size() > 0) ? iq_fifo[0] : 24'h0;
    iq_empty_i  = (iq_fifo.size() == 0);
    iq_enough_i = (iq_fifo.size() >= BL);
    cpu_data_i  = (cpu_fifo.size() > 0) ? cpu_fifo[0] : '0;
    cpu_valid_i = (cpu_fifo.size() > 0) && (cpu_gap == 0);
  endfunction

  // Monitor and FIFO model: sample before the edge settles, update inputs #1 later.
  always @(posedge clk) begin
    p_iq  = iq_rd_o;
    p_cpu = cpu_rd_o;
    p_ack = cpu_ack_o;
    if (!rst) begin
      cyc++;
      if (ft_we_o && !ft_full_i) obs_q.push_back(ft_data_o);
      if (pkt_done_o) begin done_cnt++; done_word = ft_data_o; done_cyc = cyc; end
      if (cpu_ack_o) begin ack_cnt++; ack_cyc = cyc; end
      if (cpu_rd_o) cpu_rd_cnt++;
      if (ft_we_o && ft_full_i && (iq_rd_o || cpu_rd_o)) pop_viol++;
    end
    #1;
    if (p_iq && iq_fifo.size() > 0) void'(iq_fifo.pop_front());
    if (p_cpu && cpu_fifo.size() > 0) begin
      void'(cpu_fifo.pop_front());
      if (cpu_gap_arm) begin cpu_gap = 2; cpu_gap_arm = 1'b0; end
    end else if (cpu_gap > 0) begin
      cpu_gap--;
    end
    if (p_ack) begin
      if (cpu_acks_left > 0) cpu_acks_left--;
      if (cpu_acks_left == 0) cpu_req_i = 1'b0;
    end
    fifo_refresh();
  end

  task automatic clear_counts();
    obs_q.delete();
    exp_q.delete();
    done_cnt = 0; ack_cnt = 0; cpu_rd_cnt = 0; pop_viol = 0;
    done_cyc = 0; ack_cyc = 0; done_word = '0;
  endtask

  task automatic wait_done(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && done_cnt < n; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check({tag, "_done_cnt"}, done_cnt, n);
  endtask

  task automatic compare_words(input string tag);
    check({tag, "_nwords"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), obs_q[i], exp_q[i]);
  endtask

  task automatic load_iq();
    for (int i = 0; i < 4; i++) iq_fifo.push_back(t_pair[i]);
    fifo_refresh();
  endtask

  task automatic push_iq_exp();
    exp_q.push_back(32'h00000004);
    for (int i = 0; i < 4; i++) exp_q.push_back(t_word[i]);
  endtask

  task automatic wait_obs(input int n, input int budget);
    for (int i = 0; i < budget && obs_q.size() < n; i++) @(negedge clk);
    check("wait_obs", (obs_q.size() >= n), 1);
  endtask

  initial begin
    rst = 1'b1; en_i = 1'b0; cpu_req_i = 1'b0; cpu_len_i = 8'h0; ft_full_i = 1'b0;
    fifo_refresh();
    clear_counts();
    repeat (3) @(negedge clk);
    check("rst_data", ft_data_o, 32'h0);
    check("rst_we", ft_we_o, 0);
    check("rst_ack", cpu_ack_o, 0);
    check("rst_done", pkt_done_o, 0);
    check("rst_rd", {iq_rd_o, cpu_rd_o}, 0);
    rst = 1'b0;
    en_i = 1'b1;
    @(negedge clk);

    // 1: single IQ burst
    clear_counts();
    load_iq();
    push_iq_exp();
    wait_done("t1", 1, 40);
    compare_words("t1");
    check("t1_done_word", done_word, 32'h0FFF0000);

    // 2: CPU packet of 3 words
    clear_counts();
    for (int i = 0; i < 3; i++) cpu_fifo.push_back(c_word[i]);
    fifo_refresh();
    cpu_len_i = 8'd3; cpu_acks_left = 1; cpu_req_i = 1'b1;
    exp_q.push_back(32'h80300000);
    for (int i = 0; i < 3; i++) exp_q.push_back(c_word[i]);
    wait_done("t2", 1, 40);
    compare_words("t2");
    check("t2_acks", ack_cnt, 1);

    // 3: zero-length CPU packet
    clear_counts();
    cpu_len_i = 8'd0; cpu_acks_left = 1; cpu_req_i = 1'b1;
    exp_q.push_back(32'h80000000);
    wait_done("t3", 1, 40);
    compare_words("t3");
    check("t3_cpu_rd", cpu_rd_cnt, 0);
    check("t3_acks", ack_cnt, 1);

    // 4: both sources requesting continuously
    clear_counts();
    for (int k = 0; k < 3; k++) load_iq();
    for (int i = 0; i < 3; i++) cpu_fifo.push_back(c_word[i]);
    fifo_refresh();
    cpu_len_i = 8'd1; cpu_acks_left = 3; cpu_req_i = 1'b1;
`ifdef SEL_A2F_CPU_PRIO_EN
    for (int k = 0; k < 3; k++) begin exp_q.push_back(32'h80100000); exp_q.push_back(c_word[k]); end
    for (int k = 0; k < 3; k++) push_iq_exp();
`else
    for (int k = 0; k < 3; k++) begin
      push_iq_exp();
      exp_q.push_back(32'h80100000);
      exp_q.push_back(c_word[k]);
    end
`endif
    wait_done("t4", 6, 200);
    compare_words("t4");

    // 5a: downstream full for 5 cycles mid-burst
    clear_counts();
    load_iq();
    push_iq_exp();
    wait_obs(3, 40);
    begin
      logic [31:0] held;
      ft_full_i = 1'b1;
      held = ft_data_o;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check("t5_hold_data", ft_data_o, held);
        check("t5_hold_we", ft_we_o, 1);
      end
      ft_full_i = 1'b0;
    end
    wait_done("t5a", 1, 40);
    compare_words("t5a");
    check("t5_pop_while_full", pop_viol, 0);

    // 5b: CPU source stalls 2 cycles after the first word
    clear_counts();
    for (int i = 0; i < 3; i++) cpu_fifo.push_back(c_word[i]);
    cpu_gap_arm = 1'b1;
    fifo_refresh();
    cpu_len_i = 8'd3; cpu_acks_left = 1; cpu_req_i = 1'b1;
    exp_q.push_back(32'h80300000);
    for (int i = 0; i < 3; i++) exp_q.push_back(c_word[i]);
    wait_done("t5b", 1, 40);
    compare_words("t5b");
    check("t5b_latency", done_cyc - ack_cyc, 5);

    // 6: asynchronous reset mid-burst, then enable gating
    clear_counts();
    load_iq();
    wait_obs(2, 40);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_we", ft_we_o, 0);
    check("t6_rst_data", ft_data_o, 32'h0);
    check("t6_rst_done_ack", {pkt_done_o, cpu_ack_o}, 0);
    check("t6_rst_rd", {iq_rd_o, cpu_rd_o}, 0);
    iq_fifo.delete();
    en_i = 1'b0;
    fifo_refresh();
    @(negedge clk);
    rst = 1'b0;
    clear_counts();
    load_iq();
    repeat (6) @(negedge clk);
    check("t6_en0_words", obs_q.size(), 0);
    check("t6_en0_we", ft_we_o, 0);
    en_i = 1'b1;
    push_iq_exp();
    wait_done("t6", 1, 40);
    compare_words("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
